// File: rtl/hub75_scan_ctrl_if.sv
// Renderer and panel-side signal bundle for hub75_scan_ctrl.
// master: the scan controller (drives coordinates and panel pins, reads colours).
// slave : the renderer / panel side.
interface hub75_scan_ctrl_if #(
    parameter int NUM_PIXELS = 128,
    parameter int NUM_LINES  = 32
);
    localparam int PIX_W  = $clog2(NUM_PIXELS) + 1;
    localparam int LINE_W = $clog2(NUM_LINES) + 1;
    localparam int ADDR_W = $clog2(NUM_LINES);

    logic [PIX_W-1:0]  pixel_counter_out;
    logic [LINE_W-1:0] line_counter_out;
    logic [2:0]        rgb0_in;
    logic [2:0]        rgb1_in;
    logic [2:0]        rgb0_out;
    logic [2:0]        rgb1_out;
    logic              panel_clk_out;
    logic              panel_lat_out;
    logic              panel_oe_n_out;
    logic [ADDR_W-1:0] panel_addr_out;
    logic              frame_done_out;

    modport master (
        output pixel_counter_out, line_counter_out,
        output rgb0_out, rgb1_out,
        output panel_clk_out, panel_lat_out, panel_oe_n_out, panel_addr_out,
        output frame_done_out,
        input  rgb0_in, rgb1_in
    );

    modport slave (
        input  pixel_counter_out, line_counter_out,
        input  rgb0_out, rgb1_out,
        input  panel_clk_out, panel_lat_out, panel_oe_n_out, panel_addr_out,
        input  frame_done_out,
        output rgb0_in, rgb1_in
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: shifts one row of pixels, blanks, latches, then
// displays it while the next row is shifted in.
// Optional build macro HUB75_DIM_EN adds brightness_in and a 16-step PWM
// gate on oe_n during SHIFT and DISPLAY.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | stopped, panel dark, counters cleared, waits for enable
// ST_SHIFT   | clocking pixels out, previous row stays lit if shown
// ST_BLANK   | panel dark, row address updated
// ST_LATCH   | one-cycle latch pulse, marks a row as shown
// ST_DISPLAY | panel lit for the display hold, then next row or idle
module hub75_scan_ctrl #(
    parameter int NUM_PIXELS     = 128,
    parameter int NUM_LINES      = 32,
    parameter int CLK_DIV        = 2,
    parameter int BLANK_CYCLES   = 4,
    parameter int DISPLAY_CYCLES = 64
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               enable_in,
`ifdef HUB75_DIM_EN
    input  logic [3:0]         brightness_in,
`endif
    hub75_scan_ctrl_if.master  bus
);
    localparam int PIX_W  = $clog2(NUM_PIXELS) + 1;
    localparam int LINE_W = $clog2(NUM_LINES) + 1;
    localparam int ADDR_W = $clog2(NUM_LINES);

    localparam int TMR_MAX_A = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > DISPLAY_CYCLES) ? TMR_MAX_A : DISPLAY_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0]  CLK_LOAD   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0]  BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  DISP_LOAD  = TMR_W'((DISPLAY_CYCLES > 0) ? DISPLAY_CYCLES - 1 : 0);
    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic              half, half_nxt;
    logic [PIX_W-1:0]  pixel_cnt, pixel_nxt;
    logic [LINE_W-1:0] line_cnt, line_nxt;
    logic              shown, shown_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [2:0]        rgb0_q, rgb0_nxt;
    logic [2:0]        rgb1_q, rgb1_nxt;
    logic              row_done;
    logic              panel_clk;
    logic              panel_lat;
    logic              base_oe_n;
    logic              frame_done;
    logic              oe_n;

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            half      <= 1'b0;
            pixel_cnt <= '0;
            line_cnt  <= '0;
            shown     <= 1'b0;
            addr      <= '0;
            rgb0_q    <= '0;
            rgb1_q    <= '0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            half      <= half_nxt;
            pixel_cnt <= pixel_nxt;
            line_cnt  <= line_nxt;
            shown     <= shown_nxt;
            addr      <= addr_nxt;
            rgb0_q    <= rgb0_nxt;
            rgb1_q    <= rgb1_nxt;
        end
    end

    // next-state, timer/counter updates and panel strobes
    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        half_nxt   = half;
        pixel_nxt  = pixel_cnt;
        line_nxt   = line_cnt;
        shown_nxt  = shown;
        addr_nxt   = addr;
        rgb0_nxt   = rgb0_q;
        rgb1_nxt   = rgb1_q;
        row_done   = 1'b0;
        panel_clk  = 1'b0;
        panel_lat  = 1'b0;
        base_oe_n  = 1'b1;
        frame_done = 1'b0;

        case (state)
            ST_IDLE: begin
                pixel_nxt = '0;
                line_nxt  = '0;
                if (enable_in) begin
                    state_nxt = ST_SHIFT;
                    tmr_nxt   = CLK_LOAD;
                    half_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
                panel_clk = half;
                base_oe_n = !shown;
                // renderer output is valid for the current pixel on the first low cycle
                if (!half && (tmr == CLK_LOAD)) begin
                    rgb0_nxt = bus.rgb0_in;
                    rgb1_nxt = bus.rgb1_in;
                end
                if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end else if (!half) begin
                    half_nxt = 1'b1;
                    tmr_nxt  = CLK_LOAD;
                end else if (pixel_cnt == PIX_LAST) begin
                    pixel_nxt = '0;
                    half_nxt  = 1'b0;
                    state_nxt = ST_BLANK;
                    tmr_nxt   = BLANK_LOAD;
                end else begin
                    pixel_nxt = pixel_cnt + 1'b1;
                    half_nxt  = 1'b0;
                    tmr_nxt   = CLK_LOAD;
                end
            end
            ST_BLANK: begin
                if (tmr == BLANK_LOAD) begin
                    addr_nxt = line_cnt[ADDR_W-1:0];
                end
                if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end else begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                panel_lat = 1'b1;
                shown_nxt = 1'b1;
                // with no display hold the row ends here
                if (DISPLAY_CYCLES == 0) begin
                    row_done = 1'b1;
                end else begin
                    state_nxt = ST_DISPLAY;
                    tmr_nxt   = DISP_LOAD;
                end
            end
            ST_DISPLAY: begin
                base_oe_n = 1'b0;
                if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end else begin
                    row_done = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (row_done) begin
            frame_done = (line_cnt == LINE_LAST);
            line_nxt   = (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
            if (enable_in) begin
                state_nxt = ST_SHIFT;
                tmr_nxt   = CLK_LOAD;
                half_nxt  = 1'b0;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

`ifdef HUB75_DIM_EN
    logic [3:0] pwm;

    // free-running PWM phase for brightness gating
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + 1'b1;
        end
    end

    assign oe_n = base_oe_n |
                  (((state == ST_SHIFT) || (state == ST_DISPLAY)) && (pwm >= brightness_in));
`else
    assign oe_n = base_oe_n;
`endif

    assign bus.pixel_counter_out = pixel_cnt;
    assign bus.line_counter_out  = line_cnt;
    assign bus.rgb0_out          = rgb0_q;
    assign bus.rgb1_out          = rgb1_q;
    assign bus.panel_clk_out     = panel_clk;
    assign bus.panel_lat_out     = panel_lat;
    assign bus.panel_oe_n_out    = oe_n;
    assign bus.panel_addr_out    = addr;
    assign bus.frame_done_out    = frame_done;
endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Scan sequencer for the HUB75 LED panel.
- Generates pixel/line coordinates for the combinational face renderer and registers the returned rgb0/rgb1 colours. rgb0 is the upper half of the panel and rgb1 the lower half.
- Drives the panel shift clock, latch, output-enable and row address.
- Sits between the face renderer and the top-level panel pins.

Parameters:
- NUM_PIXELS, 128: columns shifted per row.
- NUM_LINES, 32: row addresses per panel half.
- CLK_DIV, 2: system cycles per panel_clk phase (low and high). Must be >= 2.
- BLANK_CYCLES, 4: cycles oe_n is held high before and around the latch. Must be >= 1.
- DISPLAY_CYCLES, 64: extra oe_n-low hold after the latch. 0 is allowed.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: synchronous active-low reset.
- enable_in, input, 1: run scanning.
- rgb0_in, input, 3: renderer colour for the upper half at pixel_counter_out/line_counter_out.
- rgb1_in, input, 3: renderer colour for the lower half.
- pixel_counter_out, output, $clog2(NUM_PIXELS)+1: column being fetched.
- line_counter_out, output, $clog2(NUM_LINES)+1: row being fetched.
- rgb0_out, output, 3: registered panel R0/G0/B0.
- rgb1_out, output, 3: registered panel R1/G1/B1.
- panel_clk_out, output, 1: panel shift clock.
- panel_lat_out, output, 1: panel latch, active high.
- panel_oe_n_out, output, 1: panel output enable, active low.
- panel_addr_out, output, $clog2(NUM_LINES): displayed row address.
- frame_done_out, output, 1: one-cycle pulse at the end of each frame.

Behaviour:
- Reset values (any cycle with rst_n_in=0, taking effect at the next edge):
  - state=IDLE; pixel/line counters=0; rgb outputs=0.
  - panel_clk=0, lat=0, oe_n=1, addr=0, frame_done=0.
  - shown flag cleared. shown flag = "a row has been latched".
- Reset mid-operation aborts immediately; no partial latch is issued.
- State IDLE:
  - oe_n=1, clk=0, lat=0.
  - Goes to SHIFT when enable_in=1 on a clock edge; pixel and line counters are 0.
- State SHIFT: each pixel p takes 2*CLK_DIV cycles.
  - Low phase, CLK_DIV cycles, panel_clk=0. On the first low cycle, rgb0_in/rgb1_in are sampled into rgb*_out, so data is valid from low-phase cycle 1 onward. The renderer is combinational and sees pixel_counter_out in the same cycle.
  - High phase, CLK_DIV cycles, panel_clk=1. Data is held stable.
  - Then pixel_counter increments.
  - After p=NUM_PIXELS-1 completes its high phase, pixel_counter returns to 0 and the state goes to BLANK.
  - oe_n = !shown during SHIFT, so the previously latched row stays lit with addr unchanged.
- State BLANK:
  - oe_n=1, clk=0, for BLANK_CYCLES cycles.
  - panel_addr_out <= line_counter on the first BLANK cycle.
  - Then goes to LATCH.
- State LATCH:
  - One cycle; lat=1, oe_n=1.
  - Sets shown.
  - Then goes to DISPLAY.
- State DISPLAY:
  - oe_n=0 for DISPLAY_CYCLES cycles. If DISPLAY_CYCLES=0 the state is a zero-length pass-through, entered and left in the same cycle.
  - On exit, line_counter increments. NUM_LINES-1 wraps to 0, and frame_done_out pulses 1 on that exit cycle.
  - On exit, if enable_in=1 go to SHIFT; else go to IDLE. In IDLE, oe_n=1 and shown stays set.
- enable_in is sampled only in IDLE and at DISPLAY exit. Deassertion mid-row completes the row through the latch.
- Cycles per row = 2*CLK_DIV*NUM_PIXELS + BLANK_CYCLES + 1 + DISPLAY_CYCLES.
- Counters are unsigned and never exceed NUM_PIXELS-1 or NUM_LINES-1.

Optional Feature:
- Macro: HUB75_DIM_EN.
- When defined:
  - Adds the input port brightness_in, 4 bits, and a free-running 4-bit pwm counter that is reset to 0.
  - In the SHIFT and DISPLAY states, oe_n_out = base_oe_n | (pwm >= brightness_in).
  - brightness_in=0 keeps the panel dark; brightness_in=15 gives 15/16 duty.
  - BLANK, LATCH and IDLE are unaffected.
- When undefined: no port; oe_n equals base_oe_n.

Test Plan:
- Reset, frame count and wrap:
  - Setup: NUM_PIXELS=4, NUM_LINES=4, CLK_DIV=2, BLANK_CYCLES=2, DISPLAY_CYCLES=3; hold enable_in=1 after reset.
  - Response: each row takes 22 cycles; frame_done pulses every 88 cycles; line_counter_out goes 0,1,2,3,0.
- Data capture:
  - Stimulus: renderer model returns rgb0_in=pixel[2:0] and rgb1_in=~pixel[2:0].
  - Response: at every panel_clk rising edge, rgb0_out=p and rgb1_out=~p, for p=0..3.
- Latch and blanking order:
  - Response: panel_addr_out changes only while oe_n=1.
  - lat is high for exactly 1 cycle per row, always with oe_n=1 and panel_clk=0.
  - The first row after reset keeps oe_n=1 through SHIFT.
- Disable mid-row:
  - Stimulus: drop enable_in at pixel 1 of row 2.
  - Response: row 2 still latches with addr=2, the controller then enters IDLE with oe_n=1 and panel_clk=0, and the pixel counter is 0.
- Reset mid-SHIFT:
  - Stimulus: assert rst_n_in=0 for 1 cycle during the high phase.
  - Response: on the next edge all outputs are at their reset values and no lat pulse occurs.
- HUB75_DIM_EN brightness:
  - brightness_in=4: oe_n is low for 4 of every 16 cycles in DISPLAY.
  - brightness_in=0: oe_n is never low.
